// File: rtl/eeprom_i2c_ctrl.sv
// eeprom_i2c_ctrl: byte-level I2C EEPROM command controller (24C02-style page buffer, commit, busy timing)
`timescale 1ns/1ps
module eeprom_i2c_ctrl #(
    parameter logic [6:0] DEV_ADDR  = 7'h50,
    parameter int         WR_CYCLES = 1000,
    parameter int         CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       ack_valid,
    output logic       ack,
    input  logic       tx_req,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic [4:0] mem_row,
    output logic [2:0] mem_col,
    output logic       mem_write,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata
);
    typedef enum logic [2:0] {IDLE, DEVADR, WORD, WDATA, READ, IGNORE, COMMIT, WAIT} state_t;

    state_t           state, state_n;
    logic [7:0]       ptr;
    logic [7:0]       wbuf [8];
    logic [7:0]       mask;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             rx_take, acc, acc_ack, dev_ok;

    // a byte arriving together with start or stop is dropped
    assign rx_take = rx_valid && !start && !stop;
    assign dev_ok  = (rx_data[7:1] == DEV_ADDR) && !busy;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // next state and byte acceptance; commit/wait ignore bus framing but NACK any byte
    always_comb begin
        state_n = state;
        acc     = 1'b0;
        acc_ack = 1'b0;
        case (state)
            COMMIT: begin
                state_n = (idx == 3'd7) ? WAIT : COMMIT;
                acc     = rx_take;
            end
            WAIT: begin
                state_n = (cnt == CNT_W'(WR_CYCLES - 1)) ? IDLE : WAIT;
                acc     = rx_take;
            end
            default: begin
                if (start) state_n = DEVADR;
                else if (stop) state_n = (state == WDATA && mask != 8'h00) ? COMMIT : IDLE;
                else if (rx_take) begin
                    acc     = state inside {DEVADR, WORD, WDATA, IGNORE};
                    acc_ack = (state == DEVADR) ? dev_ok : (state == WORD || state == WDATA);
                    if (state == DEVADR) state_n = dev_ok ? (rx_data[0] ? READ : WORD) : IGNORE;
                    if (state == WORD) state_n = WDATA;
                end
            end
        endcase
    end

    // pointer, page buffer, commit index, busy counter and bus responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= 8'h00;
            mask      <= 8'h00;
            idx       <= 3'd0;
            cnt       <= '0;
            ack_valid <= 1'b0;
            ack       <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'h00;
            for (int i = 0; i < 8; i++) wbuf[i] <= 8'h00;
        end else begin
            ack_valid <= acc;
            ack       <= acc_ack;
            tx_valid  <= 1'b0;
            if (state == COMMIT) idx <= idx + 3'd1;
            if (state == WAIT) cnt <= (state_n == IDLE) ? '0 : cnt + 1'b1;
            if (start && !busy) mask <= 8'h00;
            if (rx_take && state == WORD) ptr <= rx_data;
            if (rx_take && state == WDATA) begin
                wbuf[ptr[2:0]] <= rx_data;
                mask[ptr[2:0]] <= 1'b1;
                ptr[2:0]       <= ptr[2:0] + 3'd1;
            end
            if (tx_req && state == READ && !start && !stop) begin
                tx_valid <= 1'b1;
                tx_data  <= mem_rdata;
                ptr      <= ptr + 8'd1;
            end
        end
    end

    // array interface: commit walks the page by idx, otherwise it follows the pointer
    always_comb begin
        busy      = (state == COMMIT) || (state == WAIT);
        mem_row   = ptr[7:3];
        mem_col   = (state == COMMIT) ? idx : ptr[2:0];
        mem_write = (state == COMMIT) && mask[idx];
        mem_wdata = (state == COMMIT) ? wbuf[idx] : 8'h00;
    end
endmodule

// File: tb/tb_eeprom_i2c_ctrl.sv
// tb_eeprom_i2c_ctrl: randomized scoreboard bench against a transaction-level EEPROM model
`timescale 1ns/1ps
module tb_eeprom_i2c_ctrl;
    localparam int WR = 40;

    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, rx_valid = 1'b0, tx_req = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ack_valid, ack, tx_valid, busy, mem_write;
    logic [7:0] tx_data, mem_wdata, mem_rdata;
    logic [4:0] mem_row;
    logic [2:0] mem_col;
    logic       load = 1'b1;

    logic [7:0]  arr   [256];
    logic [7:0]  m_mem [256];
    logic [7:0]  m_ptr = 8'h00;
    logic        ack_q [$];
    logic [7:0]  tx_q  [$];
    logic [15:0] wr_q  [$];
    logic [7:0]  wdat  [$];
    int          checks = 0, passed = 0;

    eeprom_i2c_ctrl #(.DEV_ADDR(7'h50), .WR_CYCLES(WR), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .rx_valid(rx_valid), .rx_data(rx_data), .ack_valid(ack_valid), .ack(ack),
        .tx_req(tx_req), .tx_valid(tx_valid), .tx_data(tx_data), .busy(busy),
        .mem_row(mem_row), .mem_col(mem_col), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // downstream array: seeded from the model's initial contents, then written by the DUT
    assign mem_rdata = arr[{mem_row, mem_col}];
    always @(posedge clk) begin
        if (load) for (int i = 0; i < 256; i++) arr[i] <= m_mem[i];
        else if (mem_write) arr[{mem_row, mem_col}] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic unexp(input string name, input logic [31:0] act);
        checks++;
        $display("FAIL %s: unexpected output %0h, expected none", name, act);
    endtask

    // monitor: pops the scoreboard whenever the DUT presents a response
    always @(negedge clk) begin
        if (rst_n) begin
            if (ack_valid) begin
                if (ack_q.size() == 0) unexp("ack", 32'(ack));
                else chk("ack", 32'(ack), 32'(ack_q.pop_front()));
            end
            if (tx_valid) begin
                if (tx_q.size() == 0) unexp("tx_data", 32'(tx_data));
                else chk("tx_data", 32'(tx_data), 32'(tx_q.pop_front()));
            end
            if (mem_write) begin
                if (wr_q.size() == 0) unexp("mem_write", 32'({mem_row, mem_col, mem_wdata}));
                else chk("mem_write", 32'({mem_row, mem_col, mem_wdata}), 32'(wr_q.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic p_start();
        cyc(); start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic p_stop();
        cyc(); stop = 1'b1; cyc(); stop = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit has, input bit a);
        if (has) ack_q.push_back(a);
        cyc(); rx_valid = 1'b1; rx_data = b; cyc(); rx_valid = 1'b0;
    endtask

    task automatic rd_byte();
        tx_q.push_back(m_mem[m_ptr]);
        m_ptr = m_ptr + 8'd1;
        cyc(); tx_req = 1'b1; cyc(); tx_req = 1'b0;
    endtask

    task automatic busy_len();
        int t = 0, n = 0;
        do begin @(negedge clk); t++; end while (!busy && t < 40);
        chk("busy_rise", 32'(busy), 32'd1);
        if (busy) begin
            while (busy && n < 8 + WR + 40) begin n++; @(negedge clk); end
            chk("busy_len", 32'(n), 32'(8 + WR));
        end
    endtask

    task automatic wait_not_busy();
        int t = 0;
        while (busy && t < 8 + WR + 40) begin @(negedge clk); t++; end
        chk("busy_end", 32'(busy), 32'd0);
    endtask

    // page write of wdat at word address w; the model keeps the last byte per slot
    task automatic wr_txn(input logic [7:0] w, input bit poll);
        logic [7:0] slot [8];
        bit         used [8];
        int         n, c;
        n = wdat.size();
        for (int i = 0; i < 8; i++) begin used[i] = 1'b0; slot[i] = 8'h00; end
        p_start();
        send(8'hA0, 1, 1);
        send(w, 1, 1);
        for (int j = 0; j < n; j++) begin
            send(wdat[j], 1, 1);
            c = (int'(w[2:0]) + j) % 8;
            slot[c] = wdat[j];
            used[c] = 1'b1;
        end
        for (int k = 0; k < 8; k++) if (used[k]) begin
            wr_q.push_back({w[7:3], 3'(k), slot[k]});
            m_mem[{w[7:3], 3'(k)}] = slot[k];
        end
        m_ptr = {w[7:3], 3'((int'(w[2:0]) + n) % 8)};
        p_stop();
        if (n > 0) begin
            if (poll) begin
                p_start(); send(8'hA0, 1, 0); p_stop();
                wait_not_busy();
                p_start(); send(8'hA0, 1, 1); p_stop();
            end else busy_len();
        end
    endtask

    task automatic rd_txn(input bit set_addr, input logic [7:0] a, input int n, input bit stray);
        p_start();
        if (set_addr) begin
            send(8'hA0, 1, 1);
            send(a, 1, 1);
            m_ptr = a;
            p_start();
        end
        send(8'hA1, 1, 1);
        if (stray) send(8'($urandom), 0, 0);
        for (int i = 0; i < n; i++) rd_byte();
        p_stop();
    endtask

    task automatic bad_txn();
        logic [6:0] a7;
        a7 = 7'($urandom);
        if (a7 == 7'h50) a7 = 7'h51;
        p_start();
        send({a7, 1'($urandom)}, 1, 0);
        for (int i = 0; i < 3; i++) send(8'($urandom), 1, 0);
        p_stop();
    endtask

    task automatic rst_abort(input logic [4:0] row);
        logic [7:0] d;
        p_start();
        send(8'hA0, 1, 1);
        send({row, 3'd0}, 1, 1);
        for (int j = 0; j < 4; j++) begin
            d = 8'($urandom);
            send(d, 1, 1);
            if (j < 2) begin
                wr_q.push_back({row, 3'(j), d});
                m_mem[{row, 3'(j)}] = d;
            end
        end
        p_stop();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_abort_busy", 32'(busy), 32'd0);
        chk("rst_abort_mem_write", 32'(mem_write), 32'd0);
        m_ptr = 8'h00;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        load = 1'b0;
        chk("rst_ack_valid", 32'(ack_valid), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_mem_row", 32'(mem_row), 32'd0);
        chk("rst_mem_col", 32'(mem_col), 32'd0);
        cyc();
        rst_n = 1'b1;

        wdat = '{8'hAA, 8'hBB, 8'hCC};
        wr_txn(8'h13, 0);
        wdat = '{8'h11, 8'h22, 8'h33, 8'h44};
        wr_txn(8'h1E, 0);
        rd_txn(0, 8'h00, 1, 0);
        wdat = '{8'h5A, 8'hC3};
        wr_txn(8'h40, 1);
        rd_txn(1, 8'hFF, 2, 1);
        bad_txn();
        rd_txn(0, 8'h00, 1, 0);

        cyc(); start = 1'b1; rx_valid = 1'b1; rx_data = 8'hA0; cyc(); start = 1'b0; rx_valid = 1'b0;
        send(8'hA0, 1, 1);
        send(8'h05, 1, 1);
        m_ptr = 8'h05;
        p_stop();
        cyc(); tx_req = 1'b1; cyc(); tx_req = 1'b0;
        rd_txn(0, 8'h00, 1, 0);

        rst_abort(5'd9);
        rd_txn(0, 8'h00, 1, 0);
        rd_txn(1, 8'h48, 8, 0);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0, 4: begin
                    wdat.delete();
                    repeat ($urandom_range(0, 11)) wdat.push_back(8'($urandom));
                    wr_txn(8'($urandom), 1'($urandom));
                end
                1: rd_txn(1, 8'($urandom), $urandom_range(1, 9), 1'($urandom));
                2: rd_txn(0, 8'h00, $urandom_range(1, 4), 0);
                default: bad_txn();
            endcase
        end
        rd_txn(1, 8'h00, 16, 0);

        repeat (5) cyc();
        chk("ack_q_empty", 32'(ack_q.size()), 32'd0);
        chk("tx_q_empty", 32'(tx_q.size()), 32'd0);
        chk("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
